// File: rtl/frame_deserializer.sv
// frame_deserializer
//   Receive side of the framed byte stream: HEADER, NUM_CHANNELS data bytes, FOOTER.
//   Hunts for HEADER and collects data bytes into a shadow buffer. When a matching
//   FOOTER arrives, it publishes all channels in parallel with a one-cycle valid pulse.
//
// Ports
//   clk          in   1               rising-edge clock
//   rst          in   1               synchronous active-high reset
//   din          in   8               received byte
//   din_valid    in   1               din carries a byte this cycle (low = gap)
//   dout         out  8*NUM_CHANNELS  channel k in bits [8k+7:8k], last good frame
//   dout_valid   out  1               one-cycle pulse: new good frame on dout
//   frame_err    out  1               one-cycle pulse: footer mismatch
//   timeout_err  out  1               one-cycle pulse: mid-frame idle timeout
//   frame_cnt    out  16              good-frame count, wraps modulo 2^16
//
// Optional feature macro: FRAME_TIMEOUT_EN
//   When defined, a run of TIMEOUT_CYCLES idle cycles in RECV/FOOTER aborts the frame.
//   When undefined, the receiver waits indefinitely and timeout_err is tied low.
module frame_deserializer #(
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter logic [7:0]  FOOTER         = 8'hFF,
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                din,
    input  logic                      din_valid,
    output logic [8*NUM_CHANNELS-1:0] dout,
    output logic                      dout_valid,
    output logic                      frame_err,
    output logic                      timeout_err,
    output logic [15:0]               frame_cnt
);

    generate
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 15) begin : g_bad_channels
            $error("NUM_CHANNELS must be in 1..15");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    localparam logic [3:0] LAST_IDX = 4'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_FOOTER = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                idx_q, idx_d;
    logic [8*NUM_CHANNELS-1:0] shadow_q, shadow_d;
    logic [8*NUM_CHANNELS-1:0] dout_q, dout_d;
    logic                      dout_valid_q, dout_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;
    logic                      timeout_hit;
    logic                      footer_ok;
    logic                      footer_bad;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             timeout_err_q, timeout_err_d;

    // Counts consecutive idle cycles mid-frame. Any valid byte, and every cycle
    // outside RECV/FOOTER, clears it; a valid byte at the limit therefore wins.
    always_comb begin
        gap_d       = '0;
        timeout_hit = 1'b0;
        if ((state_q == S_RECV || state_q == S_FOOTER) && !din_valid) begin
            if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    always_comb begin
        timeout_err_d = timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            gap_q         <= gap_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register and frame datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Next-state and shadow-buffer logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (din_valid && din == HEADER) begin
                    state_d = S_RECV;
                    idx_d   = '0;
                end
            end
            S_RECV: begin
                if (din_valid) begin
                    // Data bytes are stored verbatim, even if they look like HEADER/FOOTER.
                    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                        if (idx_q == 4'(k)) begin
                            shadow_d[8*k +: 8] = din;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FOOTER;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_FOOTER: begin
                // Either outcome returns to IDLE; a mismatching byte is dropped, no resync.
                if (din_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (timeout_hit) begin
            state_d = S_IDLE;
        end
    end

    // Registered outputs.
    always_comb begin
        footer_ok    = (state_q == S_FOOTER) && din_valid && (din == FOOTER);
        footer_bad   = (state_q == S_FOOTER) && din_valid && (din != FOOTER);
        dout_d       = footer_ok ? shadow_q : dout_q;
        dout_valid_d = footer_ok;
        frame_err_d  = footer_bad;
        frame_cnt_d  = footer_ok ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
